reaction_bcd_timer: RTL and testbench
=====================================

// Module: reaction_bcd_timer
// PURPOSE
//  Measures reaction time. Counts elapsed milliseconds in packed BCD while the
//  game state machine holds run high, then freezes the count as the trial result.
//  Keeps the best (smallest) valid result since reset.
//  Sits downstream of the game FSM: run <= its counting-enable output, clear <= new-trial pulse.
// PARAMETERS
//  TICK_DIV  50000  clock cycles per count increment (1 ms at 50 MHz); must be >= 2
//  DIGITS    4      BCD digits in count/best; max value is 10^DIGITS-1
// PORTS
//  clock     in   1          rising-edge clock; sole clock domain
//  reset     in   1          synchronous, active-low reset (sampled on clock rise; 0 = reset)
//  run       in   1          level: 1 = trial running (count), 0 = stopped
//  clear     in   1          one-cycle pulse: discard result, return to IDLE
//  bcd       out  4*DIGITS   current/frozen count; digit 0 (ones) in bits [3:0]
//  best      out  4*DIGITS   best valid result; all 9s when none recorded
//  best_vld  out  1          1 once at least one valid result has been stored
//  valid     out  1          1 while a frozen result is held (HOLD state)
//  overflow  out  1          1 when count saturated during current trial
//  tick      out  1          one-cycle strobe on each count increment
// BEHAVIOUR
//  Reset (reset==0 at clock rise): state=IDLE, bcd=0, prescaler=0, valid=0,
//   overflow=0, tick=0, best=all 9s, best_vld=0. Reset overrides all other inputs.
//  States: IDLE, RUN, HOLD (registered; all outputs registered).
//  IDLE: bcd=0, prescaler=0. run==1 sampled -> RUN next cycle. clear ignored.
//  RUN: prescaler increments each cycle. When prescaler==TICK_DIV-1 it wraps to 0,
//   bcd increments by 1 and tick=1 for that cycle. First increment therefore lands
//   TICK_DIV cycles after RUN entry.
//   BCD increment: digit 9 -> 0 and carries into the next digit; digits are never >9.
//   Saturation: at all-9s a further increment leaves bcd unchanged, sets overflow=1
//   and gives no tick.
//   run==0 sampled -> HOLD next cycle. The count does not increment on that edge.
//  HOLD entry (same edge): valid=1. If overflow==0 and bcd < best (unsigned BCD
//   compare, digit-wise from MSD), best<=bcd and best_vld<=1. With overflow=1, best
//   is not updated.
//  HOLD: bcd frozen; run is ignored. clear==1 -> IDLE next cycle; on that edge
//   valid, overflow and bcd are cleared to 0.
//  clear in RUN: aborts the trial -> IDLE, bcd=0, overflow=0; best untouched.
//  clear and run both 1 in HOLD: clear wins (-> IDLE). IDLE then re-enters RUN on
//   the following cycle if run is still 1.
//  A zero result (run drops before the first tick) is valid. It becomes best if it
//   is smaller than the current best.
//  Reset mid-RUN/HOLD: all state per reset values, including best.
// TESTING (TICK_DIV=4, DIGITS=4 unless noted)
//  1. Hold reset=0 for 2 cycles -> bcd=0000, best=9999, valid=0, overflow=0, best_vld=0.
//  2. run=1 for 4+4*37 cycles, then run=0 -> valid=1, bcd=0x0037, best=0x0037,
//     best_vld=1; tick pulses exactly 37 times.
//  3. Counting through 0x0099 -> next tick gives 0x0100; through 0x0999 -> 0x1000
//     (carry chain).
//  4. DIGITS=2: run held for 120 ticks -> bcd=0x99, overflow=1, no tick after 99;
//     after stop, best unchanged.
//  5. Trial 0x0037, clear, trial 0x0052 -> best stays 0x0037; then trial 0x0012
//     -> best=0x0012.
//  6. clear in RUN at 0x0005 -> IDLE, bcd=0; clear+run in HOLD -> IDLE, then RUN
//     on the next cycle; reset=0 mid-RUN -> all reset values on the next edge.

Source files
------------

// File: rtl/reaction_bcd_timer.sv
// reaction_bcd_timer: millisecond reaction timer with a packed-BCD count, a frozen
// trial result and the best (smallest) valid result held since reset.
module reaction_bcd_timer #(
    parameter int TICK_DIV = 50000,
    parameter int DIGITS   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                clear,
    output logic [4*DIGITS-1:0] bcd,
    output logic [4*DIGITS-1:0] best,
    output logic                best_vld,
    output logic                valid,
    output logic                overflow,
    output logic                tick
);

    localparam int              W         = 4 * DIGITS;
    localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]    ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;

    // Ripple-carry decimal increment; the caller guarantees the input is not all 9s.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        // NOTE: every local gets a value before any conditional use, so no storage is implied.
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise unsigned compare, decided by the most significant differing digit.
    function automatic logic bcd_less(input logic [W-1:0] a, input logic [W-1:0] b);
        logic lt;
        logic decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                lt      = (a[4*i +: 4] < b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return lt;
    endfunction

    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous and clears every register, best included, so a
        // reset mid-trial leaves no stale record behind.
        if (!reset) begin
            state     <= IDLE;
            bcd       <= '0;
            prescaler <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            tick      <= 1'b0;
            best      <= ALL_NINES;
            best_vld  <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignments so every decision below
            // sees the values from before this edge.
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    bcd       <= '0;
                    prescaler <= '0;
                    if (run) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (clear) begin
                        state     <= IDLE;
                        bcd       <= '0;
                        overflow  <= 1'b0;
                        prescaler <= '0;
                    end else if (!run) begin
                        // Freeze the result; a saturated trial never becomes best.
                        state <= HOLD;
                        valid <= 1'b1;
                        if (!overflow && bcd_less(bcd, best)) begin
                            best     <= bcd;
                            best_vld <= 1'b1;
                        end
                    end else if (prescaler == PRE_LAST) begin
                        prescaler <= '0;
                        if (bcd == ALL_NINES) begin
                            overflow <= 1'b1;
                        end else begin
                            bcd  <= bcd_inc(bcd);
                            tick <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end

                HOLD: begin
                    if (clear) begin
                        state    <= IDLE;
                        valid    <= 1'b0;
                        overflow <= 1'b0;
                        bcd      <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_bcd_timer.sv
// Self-checking bench for reaction_bcd_timer: spec-derived vector table, random
// stimulus against an integer-millisecond reference model, and a 2-digit saturation run.
module tb_reaction_bcd_timer;

    localparam int TD   = 4;
    localparam int MAXV = 9999;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run   = 1'b0;
    logic        clear = 1'b0;
    logic        run2  = 1'b0;
    logic        clear2 = 1'b0;

    logic [15:0] bcd, best;
    logic        best_vld, valid, overflow, tick;
    logic [7:0]  bcd2, best2;
    logic        best_vld2, valid2, overflow2, tick2;

    int checks = 0;
    int errors = 0;
    int ticks_seen = 0;
    int ticks2_seen = 0;

    always #5 clock = ~clock;

    reaction_bcd_timer #(.TICK_DIV(TD), .DIGITS(4)) dut (
        .clock(clock), .reset(reset), .run(run), .clear(clear),
        .bcd(bcd), .best(best), .best_vld(best_vld),
        .valid(valid), .overflow(overflow), .tick(tick)
    );

    reaction_bcd_timer #(.TICK_DIV(TD), .DIGITS(2)) dut2 (
        .clock(clock), .reset(reset), .run(run2), .clear(clear2),
        .bcd(bcd2), .best(best2), .best_vld(best_vld2),
        .valid(valid2), .overflow(overflow2), .tick(tick2)
    );

    // Reference model: elapsed milliseconds as a plain integer, converted to BCD on compare.
    int m_mode = 0;   // 0 idle, 1 counting, 2 holding a result
    int m_ms   = 0;
    int m_cyc  = 0;   // cycles counted since the last millisecond
    int m_best = MAXV;
    bit m_valid = 0, m_ovf = 0, m_tick = 0, m_bvld = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_step(input bit rs, input bit r, input bit c);
        if (!rs) begin
            m_mode = 0; m_ms = 0; m_cyc = 0; m_best = MAXV;
            m_valid = 0; m_ovf = 0; m_tick = 0; m_bvld = 0;
        end else begin
            m_tick = 0;
            if (m_mode == 0) begin
                m_ms = 0; m_cyc = 0;
                if (r) m_mode = 1;
            end else if (m_mode == 1) begin
                if (c) begin
                    m_mode = 0; m_ms = 0; m_ovf = 0; m_cyc = 0;
                end else if (!r) begin
                    m_mode = 2; m_valid = 1;
                    if (!m_ovf && m_ms < m_best) begin
                        m_best = m_ms; m_bvld = 1;
                    end
                end else begin
                    m_cyc++;
                    if (m_cyc == TD) begin
                        m_cyc = 0;
                        if (m_ms == MAXV) m_ovf = 1;
                        else begin m_ms++; m_tick = 1; end
                    end
                end
            end else if (c) begin
                m_mode = 0; m_valid = 0; m_ovf = 0; m_ms = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit rs, input bit r, input bit c,
                         input bit r2 = 1'b0, input bit c2 = 1'b0);
        @(negedge clock);
        reset = rs; run = r; clear = c; run2 = r2; clear2 = c2;
        @(posedge clock);
        model_step(rs, r, c);
        #1;
        if (tick)  ticks_seen++;
        if (tick2) ticks2_seen++;
        check("cyc_bcd",      32'(bcd),      32'(to_bcd(m_ms)));
        check("cyc_best",     32'(best),     32'(to_bcd(m_best)));
        check("cyc_best_vld", 32'(best_vld), 32'(m_bvld));
        check("cyc_valid",    32'(valid),    32'(m_valid));
        check("cyc_overflow", 32'(overflow), 32'(m_ovf));
        check("cyc_tick",     32'(tick),     32'(m_tick));
    endtask

    typedef struct {
        string       name;
        bit          rst;
        bit          run;
        bit          clr;
        int          n;
        logic [15:0] bcd;
        logic [15:0] best;
        bit          valid;
        bit          ovf;
        bit          bvld;
        int          ticks;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input bit rs, input bit r, input bit c,
                                input int n, input logic [15:0] eb, input logic [15:0] ebest,
                                input bit ev, input bit eo, input bit ebv, input int et);
        vec_t v;
        v.name = nm; v.rst = rs; v.run = r; v.clr = c; v.n = n;
        v.bcd = eb; v.best = ebest; v.valid = ev; v.ovf = eo; v.bvld = ebv; v.ticks = et;
        return v;
    endfunction

    initial begin
        int  len;
        bit  rr, rc, rrs;

        vecs.push_back(mk("reset",      0, 0, 0,    2, 16'h0000, 16'h9999, 0, 0, 0,   0));
        vecs.push_back(mk("run37",      1, 1, 0,  152, 16'h0037, 16'h9999, 0, 0, 0,  37));
        vecs.push_back(mk("hold37",     1, 0, 0,    1, 16'h0037, 16'h0037, 1, 0, 1,   0));
        vecs.push_back(mk("clear37",    1, 0, 1,    1, 16'h0000, 16'h0037, 0, 0, 1,   0));
        vecs.push_back(mk("run52",      1, 1, 0,  209, 16'h0052, 16'h0037, 0, 0, 1,  52));
        vecs.push_back(mk("hold52",     1, 0, 0,    1, 16'h0052, 16'h0037, 1, 0, 1,   0));
        vecs.push_back(mk("clear52",    1, 0, 1,    1, 16'h0000, 16'h0037, 0, 0, 1,   0));
        vecs.push_back(mk("run12",      1, 1, 0,   49, 16'h0012, 16'h0037, 0, 0, 1,  12));
        vecs.push_back(mk("hold12",     1, 0, 0,    1, 16'h0012, 16'h0012, 1, 0, 1,   0));
        vecs.push_back(mk("clear12",    1, 0, 1,    1, 16'h0000, 16'h0012, 0, 0, 1,   0));
        vecs.push_back(mk("run99",      1, 1, 0,  397, 16'h0099, 16'h0012, 0, 0, 1,  99));
        vecs.push_back(mk("carry100",   1, 1, 0,    4, 16'h0100, 16'h0012, 0, 0, 1,   1));
        vecs.push_back(mk("run999",     1, 1, 0, 3596, 16'h0999, 16'h0012, 0, 0, 1, 899));
        vecs.push_back(mk("carry1000",  1, 1, 0,    4, 16'h1000, 16'h0012, 0, 0, 1,   1));
        vecs.push_back(mk("hold1000",   1, 0, 0,    1, 16'h1000, 16'h0012, 1, 0, 1,   0));
        vecs.push_back(mk("clear1000",  1, 0, 1,    1, 16'h0000, 16'h0012, 0, 0, 1,   0));
        vecs.push_back(mk("run5",       1, 1, 0,   21, 16'h0005, 16'h0012, 0, 0, 1,   5));
        vecs.push_back(mk("abort",      1, 1, 1,    1, 16'h0000, 16'h0012, 0, 0, 1,   0));
        vecs.push_back(mk("run2",       1, 1, 0,    9, 16'h0002, 16'h0012, 0, 0, 1,   2));
        vecs.push_back(mk("hold2",      1, 0, 0,    1, 16'h0002, 16'h0002, 1, 0, 1,   0));
        vecs.push_back(mk("clear_run",  1, 1, 1,    1, 16'h0000, 16'h0002, 0, 0, 1,   0));
        vecs.push_back(mk("reenter",    1, 1, 0,    1, 16'h0000, 16'h0002, 0, 0, 1,   0));
        vecs.push_back(mk("first_ms",   1, 1, 0,    4, 16'h0001, 16'h0002, 0, 0, 1,   1));
        vecs.push_back(mk("more_ms",    1, 1, 0,    7, 16'h0002, 16'h0002, 0, 0, 1,   1));
        vecs.push_back(mk("reset_mid",  0, 1, 0,    1, 16'h0000, 16'h9999, 0, 0, 0,   0));
        vecs.push_back(mk("zero_run",   1, 1, 0,    2, 16'h0000, 16'h9999, 0, 0, 0,   0));
        vecs.push_back(mk("zero_hold",  1, 0, 0,    1, 16'h0000, 16'h0000, 1, 0, 1,   0));
        vecs.push_back(mk("hold_run",   1, 1, 0,    3, 16'h0000, 16'h0000, 1, 0, 1,   0));
        vecs.push_back(mk("zero_clear", 1, 0, 1,    1, 16'h0000, 16'h0000, 0, 0, 1,   0));

        foreach (vecs[i]) begin
            ticks_seen = 0;
            for (int j = 0; j < vecs[i].n; j++) cycle(vecs[i].rst, vecs[i].run, vecs[i].clr);
            check({vecs[i].name, "/bcd"},      32'(bcd),        32'(vecs[i].bcd));
            check({vecs[i].name, "/best"},     32'(best),       32'(vecs[i].best));
            check({vecs[i].name, "/valid"},    32'(valid),      32'(vecs[i].valid));
            check({vecs[i].name, "/overflow"}, 32'(overflow),   32'(vecs[i].ovf));
            check({vecs[i].name, "/best_vld"}, 32'(best_vld),   32'(vecs[i].bvld));
            check({vecs[i].name, "/ticks"},    32'(ticks_seen), 32'(vecs[i].ticks));
        end

        // Random trials, clear pulses and occasional resets against the reference model.
        for (int k = 0; k < 250; k++) begin
            len = $urandom_range(1, 40);
            rr  = ($urandom_range(0, 3) != 0);
            rc  = ($urandom_range(0, 9) == 0);
            rrs = ($urandom_range(0, 49) != 0);
            for (int j = 0; j < len; j++) cycle(rrs, rr, rc && (j == 0));
        end

        // Two-digit saturation: 120 ms of run on a 99 ms counter.
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("sat/reset_best", 32'(best2), 32'h99);
        ticks2_seen = 0;
        for (int j = 0; j < 397; j++) cycle(1, 0, 0, 1, 0);
        check("sat/at99_bcd", 32'(bcd2),      32'h99);
        check("sat/at99_ovf", 32'(overflow2), 32'h0);
        for (int j = 0; j < 4; j++) cycle(1, 0, 0, 1, 0);
        check("sat/first_ovf", 32'(overflow2), 32'h1);
        for (int j = 0; j < 80; j++) cycle(1, 0, 0, 1, 0);
        check("sat/bcd",   32'(bcd2),        32'h99);
        check("sat/ovf",   32'(overflow2),   32'h1);
        check("sat/ticks", 32'(ticks2_seen), 32'd99);
        cycle(1, 0, 0, 0, 0);
        check("sat/hold_valid", 32'(valid2),    32'h1);
        check("sat/hold_best",  32'(best2),     32'h99);
        check("sat/hold_bvld",  32'(best_vld2), 32'h0);
        check("sat/hold_ovf",   32'(overflow2), 32'h1);
        cycle(1, 0, 0, 0, 1);
        check("sat/clr_bcd",   32'(bcd2),      32'h0);
        check("sat/clr_ovf",   32'(overflow2), 32'h0);
        check("sat/clr_valid", 32'(valid2),    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
